ws2812_serializer: RTL and testbench
====================================

Name: ws2812_serializer

Overview:
Downstream stage of the 16-entry palette ROM. Accepts one 24-bit colour word per LED over a valid/ready handshake and drives the single-wire WS2812B data line. Each bit is encoded as a timed high/low pulse. On request, and automatically after reset, it holds the line low for the latch/reset gap. It is the last stage before the output pad of the LED-matrix driver.

Parameters:
T0H_CYCLES, 20, high time of a '0' bit in clk cycles (0.4 us at 50 MHz)
T1H_CYCLES, 40, high time of a '1' bit in clk cycles (0.8 us at 50 MHz)
BIT_CYCLES, 62, total bit period in clk cycles (1.24 us); must exceed T1H_CYCLES
LATCH_CYCLES, 15000, low time of the latch gap (300 us at 50 MHz)
CNT_W, 14, timer width; must hold LATCH_CYCLES-1

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
data  input  24  colour word in GRB order, as produced by the palette ROM; bit 23 is transmitted first
valid  input  1  data is valid
ready  output  1  block can accept a word this cycle
latch  input  1  request a latch gap (end of frame)
led_out  output  1  WS2812B serial data line
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock domain. All state is cleared asynchronously while rst_n=0.
- Reset values: state=LATCH, timer=0, led_out=0, ready=0, busy=1. The block therefore always emits a full latch gap after reset, so the strip resynchronises even if reset hit mid-word.
- States:
  - IDLE: ready=1, led_out=0.
    - valid=1: load data into the shift register, bit_idx=23, timer=0, go to HIGH.
    - else latch=1: timer=0, go to LATCH.
    - valid takes priority over latch when both are high in the same cycle; that latch is dropped.
  - HIGH: led_out=1.
    - Lasts T1H_CYCLES if the current bit (shreg[23]) is 1, T0H_CYCLES if it is 0.
    - timer counts from 0. When it reaches the high time minus 1, go to LOW. The timer keeps counting and does not reset.
  - LOW: led_out=0.
    - Lasts until timer = BIT_CYCLES-1, so each bit is exactly BIT_CYCLES cycles.
    - At that point: if bit_idx=0, go to IDLE. Otherwise shift left by 1, decrement bit_idx, set timer=0, go to HIGH.
  - LATCH: led_out=0, ready=0.
    - After LATCH_CYCLES cycles (timer reaches LATCH_CYCLES-1), go to IDLE.
    - valid and latch are ignored while in this state.
- ready is asserted only in IDLE. It is a registered state decode and is never combinational from valid.
- Latency: handshake at rising edge N puts led_out=1 from the cycle after edge N. The word occupies exactly 24*BIT_CYCLES cycles of the line. ready rises one cycle after the last LOW phase ends.
- Back-to-back words: one extra low cycle (the IDLE cycle) is inserted between words. This is well inside the WS2812B low-time tolerance.
- data is sampled only on the handshake edge; later changes to data have no effect on the word in flight.
- led_out is registered and glitch-free.
- Parameter relations (T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; LATCH_CYCLES < 2^CNT_W) are checked by an initial-block assertion in simulation only.

Optional Feature:
SERIALIZER_DIM_EN
- Defined: adds input port dim[1:0]. At the handshake, each 8-bit channel of data is logically shifted right by dim before loading: 0 = full, 3 = 1/8 brightness. dim is sampled only at the handshake.
- Undefined: no dim port exists and data is loaded unmodified. Behaviour and timing are otherwise identical.

Test Plan:
- Reset release: rst_n low mid-word, then high.
  - Required: led_out=0 immediately; ready=0 for 15000 cycles, then ready=1 and busy=0.
- Single word: data=24'h00CC00, valid pulse in IDLE.
  - Required: 24 bit periods of 62 cycles each.
  - High times 20×8, then 40,40,20,20,40,40,20,20, then 20×8.
  - ready returns 1488+1 cycles after the handshake.
- Back-to-back words: valid held high with ROM entries 0 then 15.
  - Required: second word's first high starts exactly 1 cycle after the first word's final LOW ends.
  - Total 2977 cycles; bit pattern matches 24'h00CC00 then 24'h00CC4C.
- Simultaneous events: valid=1 and latch=1 in IDLE.
  - Required: word accepted and latch dropped.
  - latch pulsed during HIGH or LOW is ignored.
  - latch alone in IDLE gives led_out=0 with ready=0 for 15000 cycles.
- Data stability: change data and toggle valid while the word is in flight.
  - Required: transmitted bits unchanged; ready stays 0.
- With SERIALIZER_DIM_EN, dim=2, data=24'hCC4C7F.
  - Required: transmitted word is 24'h33131F.

Source files
------------

// File: rtl/ws2812_serializer.sv
// ws2812_serializer: turns 24-bit GRB colour words into WS2812B pulse-width
// encoded bits on a single data line, with a latch gap on request and after reset.
// Optional feature macro: SERIALIZER_DIM_EN adds a dim[1:0] port that shifts each
// 8-bit channel right by dim when the word is accepted.

module ws2812_serializer #(
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 62,
  parameter int LATCH_CYCLES = 15000,
  parameter int CNT_W        = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data,
  input  logic        valid,
  output logic        ready,
  input  logic        latch,
  output logic        led_out,
  output logic        busy
`ifdef SERIALIZER_DIM_EN
  ,
  input  logic [1:0]  dim
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef SERIALIZER_DIM_EN
  // Scale each 8-bit channel of a GRB word down by a power of two.
  function automatic logic [23:0] dim_word(input logic [23:0] w, input logic [1:0] d);
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    g = w[23:16] >> d;
    r = w[15:8]  >> d;
    b = w[7:0]   >> d;
    return {g, r, b};
  endfunction
`endif

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nx_s;
  logic [23:0]      shreg_r;
  logic [23:0]      shreg_nx_s;
  logic [4:0]       bit_idx_r;
  logic [4:0]       bit_idx_nx_s;
  logic [CNT_W-1:0] high_last_s;
  logic [23:0]      load_word_s;

  // Word captured at the handshake (optionally dimmed).
  always_comb begin
`ifdef SERIALIZER_DIM_EN
    load_word_s = dim_word(data, dim);
`else
    load_word_s = data;
`endif
  end

  // Last timer value of the high phase for the bit currently at the MSB.
  always_comb begin
    if (shreg_r[23]) begin
      high_last_s = T1H_LAST;
    end else begin
      high_last_s = T0H_LAST;
    end
  end

  // Next-state, timer, shift register and bit index.
  always_comb begin
    state_nx_s   = state_r;
    timer_nx_s   = timer_r + CNT_ONE;
    shreg_nx_s   = shreg_r;
    bit_idx_nx_s = bit_idx_r;
    case (state_r)
      ST_IDLE: begin
        timer_nx_s = '0;
        if (valid) begin
          // A word wins over a simultaneous latch request; the latch is dropped.
          shreg_nx_s   = load_word_s;
          bit_idx_nx_s = 5'd23;
          state_nx_s   = ST_HIGH;
        end else if (latch) begin
          state_nx_s = ST_LATCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        // Timer keeps running into LOW so the whole bit is measured from its start.
        if (timer_r == high_last_s) begin
          state_nx_s = ST_LOW;
        end else begin
          state_nx_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (timer_r == BIT_LAST) begin
          timer_nx_s = '0;
          if (bit_idx_r == 5'd0) begin
            state_nx_s = ST_IDLE;
          end else begin
            shreg_nx_s   = {shreg_r[22:0], 1'b0};
            bit_idx_nx_s = bit_idx_r - 5'd1;
            state_nx_s   = ST_HIGH;
          end
        end else begin
          state_nx_s = ST_LOW;
        end
      end
      ST_LATCH: begin
        if (timer_r == LATCH_LAST) begin
          timer_nx_s = '0;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_LATCH;
        end
      end
      default: begin
        timer_nx_s = '0;
        state_nx_s = ST_LATCH;
      end
    endcase
  end

  // State, timer and datapath registers; reset forces a full latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_LATCH;
      timer_r   <= '0;
      shreg_r   <= 24'h000000;
      bit_idx_r <= 5'd0;
    end else begin
      state_r   <= state_nx_s;
      timer_r   <= timer_nx_s;
      shreg_r   <= shreg_nx_s;
      bit_idx_r <= bit_idx_nx_s;
    end
  end

  // Outputs are registered decodes of the next state, so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      led_out <= (state_nx_s == ST_HIGH);
      ready   <= (state_nx_s == ST_IDLE);
      busy    <= (state_nx_s != ST_IDLE);
    end
  end

`ifndef SYNTHESIS
  ws2812_serializer_checker #(
    .T0H_CYCLES  (T0H_CYCLES),
    .T1H_CYCLES  (T1H_CYCLES),
    .BIT_CYCLES  (BIT_CYCLES),
    .LATCH_CYCLES(LATCH_CYCLES),
    .CNT_W       (CNT_W)
  ) u_checker ();
`endif

endmodule

// Simulation-only parameter sanity checks for ws2812_serializer.
module ws2812_serializer_checker #(
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 62,
  parameter int LATCH_CYCLES = 15000,
  parameter int CNT_W        = 14
) ();

  // Reject parameter sets whose timing relations cannot work.
  initial begin
    assert ((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))
      else $error("ws2812_serializer: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    assert (LATCH_CYCLES < (2 ** CNT_W))
      else $error("ws2812_serializer: LATCH_CYCLES does not fit the CNT_W timer");
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Self-checking bench for ws2812_serializer: a queue-based waveform model is
// compared every cycle, plus directed checks with hand-computed literals.
module tb_ws2812_serializer;

  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int BITC  = 62;
  localparam int LATCH = 15000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data = 24'h000000;
  logic        valid = 1'b0;
  logic        latch = 1'b0;
  logic        ready;
  logic        led_out;
  logic        busy;
`ifdef SERIALIZER_DIM_EN
  logic [1:0]  dim = 2'd0;
`endif

  always #5 clk = ~clk;

  ws2812_serializer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .latch  (latch),
    .led_out(led_out),
    .busy   (busy)
`ifdef SERIALIZER_DIM_EN
    ,
    .dim    (dim)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- waveform model: {led_out, ready, busy} per cycle ----------------
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur = 3'b001;

  task automatic push_word(input logic [23:0] w);
    for (int b = 23; b >= 0; b--) begin
      int th;
      th = w[b] ? T1H : T0H;
      for (int c = 0; c < BITC; c++) exp_q.push_back((c < th) ? 3'b101 : 3'b001);
    end
  endtask

  task automatic push_latch(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(3'b001);
  endtask

  initial begin
    logic [23:0] w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        push_latch(LATCH - 1);
        exp_cur = 3'b001;
      end else if (exp_q.size() > 0) begin
        exp_cur = exp_q.pop_front();
      end else if (exp_cur == 3'b010 && valid) begin
        w = data;
`ifdef SERIALIZER_DIM_EN
        w = {8'(data[23:16] / (8'd1 << dim)), 8'(data[15:8] / (8'd1 << dim)),
             8'(data[7:0] / (8'd1 << dim))};
`endif
        push_word(w);
        exp_cur = exp_q.pop_front();
      end else if (exp_cur == 3'b010 && latch) begin
        push_latch(LATCH);
        exp_cur = exp_q.pop_front();
      end else begin
        exp_cur = 3'b010;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cycle_led_ready_busy", {29'd0, led_out, ready, busy}, {29'd0, exp_cur});
    end
  end

  // ---------------- high-time monitor ----------------
  int hi_q[$];
  int run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) run = 0;
      else if (led_out) run++;
      else if (run > 0) begin
        hi_q.push_back(run);
        run = 0;
      end
    end
  end

  task automatic check_word(input string nm, input int base, input logic [23:0] exp);
    logic [23:0] w;
    if (hi_q.size() < base + 24) begin
      check({nm, "_bitcount"}, hi_q.size(), base + 24);
    end else begin
      w = 24'h000000;
      for (int i = 0; i < 24; i++) w = {w[22:0], (hi_q[base + i] > 30)};
      check(nm, {8'd0, w}, {8'd0, exp});
    end
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < bound);
  endtask

  int exp_hi [24] = '{20, 20, 20, 20, 20, 20, 20, 20,
                      40, 40, 20, 20, 40, 40, 20, 20,
                      20, 20, 20, 20, 20, 20, 20, 20};

  initial begin
    int n;
    int n2;
    // reset release: full latch gap
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_ready(20000, n);
    check("reset_gap_len", n, 15000);
    check("reset_idle_busy", {31'd0, busy}, 32'd0);

    // single word 00CC00
    hi_q.delete();
    data = 24'h00CC00; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; data = 24'hFFFFFF;
    check("model_word_len", exp_q.size(), 1487);
    wait_ready(2000, n);
    check("word_ready_latency", n, 1488);
    check("word_high_count", hi_q.size(), 24);
    if (hi_q.size() == 24) begin
      for (int i = 0; i < 24; i++) check("word_high_time", hi_q[i], exp_hi[i]);
    end
    check_word("word0_bits", 0, 24'h00CC00);

    // back-to-back words with valid held high
    hi_q.delete();
    data = 24'h00CC00; valid = 1'b1;
    @(negedge clk);
    data = 24'h00CC4C;
    wait_ready(2000, n);
    check("b2b_first_end", n, 1488);
    @(negedge clk);
    valid = 1'b0; data = 24'h000000;
    wait_ready(2000, n2);
    check("b2b_total", n + 1 + n2, 2977);
    check_word("b2b_word0", 0, 24'h00CC00);
    check_word("b2b_word1", 24, 24'h00CC4C);

    // data stability: data and valid churn while the word is in flight
    hi_q.delete();
    data = 24'hA55A3C; valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1400; i++) begin
      data = 24'($urandom);
      valid = i[0];
      @(negedge clk);
      if (i % 200 == 0) check("stable_ready_low", {31'd0, ready}, 32'd0);
    end
    valid = 1'b0;
    wait_ready(2000, n);
    check("stable_ready_latency", n, 88);
    check_word("stable_bits", 0, 24'hA55A3C);

    // valid and latch together; latch pulses in HIGH and LOW ignored
    hi_q.delete();
    data = 24'h123456; valid = 1'b1; latch = 1'b1;
    @(negedge clk);
    valid = 1'b0; latch = 1'b0;
    repeat (10) @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    repeat (30) @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    wait_ready(2000, n);
    check("simul_ready_latency", n, 1446);
    @(negedge clk);
    check("simul_latch_dropped", {31'd0, ready}, 32'd1);
    check_word("simul_bits", 0, 24'h123456);

    // latch alone in IDLE
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    check("latch_led_low", {31'd0, led_out}, 32'd0);
    wait_ready(20000, n);
    check("latch_gap_len", n, 15000);

`ifdef SERIALIZER_DIM_EN
    hi_q.delete();
    dim = 2'd2; data = 24'hCC4C7F; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; dim = 2'd0;
    wait_ready(2000, n);
    check("dim_bits_latency", n, 1488);
    check_word("dim_bits", 0, 24'h33131F);
`endif

    // reset in the middle of a word
    data = 24'hFFFFFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midword_led_high", {31'd0, led_out}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midword_reset_led", {31'd0, led_out}, 32'd0);
    check("midword_reset_ready", {31'd0, ready}, 32'd0);
    check("midword_reset_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_ready(20000, n);
    check("midword_gap_len", n, 15000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
